// File: rtl/rx_pkg.sv
// Shared UART receive-side definitions.
// Holds the frame width, the FSM state encoding and the bit-counter sizing helper.
package rx_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // The counter must reach DATA_WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int UART_CNT_WIDTH = cnt_width(UART_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/rx_if.sv
// Parallel and serial signals of the receive path.
// The line driver and checker use master; the receiver side uses slave.
interface rx_if
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);

  logic                  rx_in;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  parity_bit_error;
  logic                  stop_bit_error;

  modport master (
    output rx_in,
    input  rx_data,
    input  parity_bit_error,
    input  stop_bit_error
  );

  modport slave (
    input  rx_in,
    output rx_data,
    output parity_bit_error,
    output stop_bit_error
  );

endinterface

// File: rtl/rx_shift_reg.sv
// Right-shift deserialiser: new serial bits enter at the MSB.
// After DATA_WIDTH shifts the first received bit sits in the LSB.
module rx_shift_reg
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {serial_in, data[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rx_top.sv
// UART receive front end clocked at the bit rate.
// Deserialises a start/data/even-parity/stop frame and registers the result and error flags.
module rx_top
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic                  rx_in,
  output logic                  parity_bit_error,
  output logic                  stop_bit_error,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  parity_rx;
  logic [DATA_WIDTH-1:0] shift_data;
  logic                  shift_clear;
  logic                  shift_en;

  // The shift register is cleared on reset and again when a start bit is confirmed.
  assign shift_clear = !rx_rst_n || (state == START && !rx_in);
  assign shift_en    = (state == DATA);

  rx_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk       (rx_clk),
    .clear     (shift_clear),
    .shift_en  (shift_en),
    .serial_in (rx_in),
    .data      (shift_data)
  );

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      parity_rx        <= 1'b0;
      rx_data          <= '0;
      parity_bit_error <= 1'b0;
      stop_bit_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state <= START;
          end
        end
        START: begin
          if (!rx_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= PARITY;
          end
        end
        PARITY: begin
          parity_rx <= rx_in;
          state     <= STOP;
        end
        // The frame is delivered even when a flag is raised.
        STOP: begin
          rx_data          <= shift_data;
          parity_bit_error <= parity_rx ^ (^shift_data);
          stop_bit_error   <= ~rx_in;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_top.sv
// Self-checking bench for rx_top: a table of framed vectors plus directed
// sequences for false start, mid-frame reset and back-to-back frames.
module tb_rx_top;
  import rx_pkg::*;

  localparam int W = UART_DATA_WIDTH;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    logic         stop;
    logic [W-1:0] exp_data;
    logic         exp_pe;
    logic         exp_se;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rx_if #(.DATA_WIDTH(W)) bus ();

  rx_top #(.DATA_WIDTH(W)) dut (
    .rx_clk           (clk),
    .rx_rst_n         (rst_n),
    .rx_in            (bus.rx_in),
    .parity_bit_error (bus.parity_bit_error),
    .stop_bit_error   (bus.stop_bit_error),
    .rx_data          (bus.rx_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [W-1:0] d,
                               input logic pe, input logic se);
    check({name, ".data"}, 32'(bus.rx_data), 32'(d));
    check({name, ".parity_err"}, 32'(bus.parity_bit_error), 32'(pe));
    check({name, ".stop_err"}, 32'(bus.stop_bit_error), 32'(se));
  endtask

  // Drive one bit away from the active edge, then return just after the edge that sampled it.
  task automatic tick(input logic b);
    @(negedge clk);
    bus.rx_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Full frame; before the stop edge the previous result must still be held.
  task automatic send_frame(input string name, input logic [W-1:0] d, input logic p,
                            input logic s, input logic [W-1:0] hold_data);
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < W; i++) tick(d[i]);
    tick(p);
    check({name, ".hold"}, 32'(bus.rx_data), 32'(hold_data));
    tick(s);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};

    bus.rx_in = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_outputs("idle_after_reset", '0, 1'b0, 1'b0);

    begin
      logic [W-1:0] prev;
      prev = '0;
      for (int i = 0; i < 7; i++) begin
        send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop, prev);
        check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_se);
        idle(3);
        check_outputs($sformatf("vec%0d_idle", i), vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_se);
        prev = vecs[i].exp_data;
      end
    end

    // Good frame clears the flags left by the last table entry.
    send_frame("clear", 8'h3C, 1'b0, 1'b1, 8'hFF);
    check_outputs("clear", 8'h3C, 1'b0, 1'b0);
    idle(2);

    tick(1'b0);
    idle(3);
    check_outputs("false_start", 8'h3C, 1'b0, 1'b0);
    send_frame("after_false", 8'hC3, 1'b0, 1'b1, 8'h3C);
    check_outputs("after_false", 8'hC3, 1'b0, 1'b0);
    idle(2);

    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.rx_in = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("mid_reset", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check_outputs("post_reset_idle", '0, 1'b0, 1'b0);
    send_frame("after_reset", 8'hFF, 1'b0, 1'b1, 8'h00);
    check_outputs("after_reset", 8'hFF, 1'b0, 1'b0);
    idle(1);

    send_frame("b2b_a", 8'h01, 1'b1, 1'b1, 8'hFF);
    check_outputs("b2b_a", 8'h01, 1'b0, 1'b0);
    send_frame("b2b_b", 8'h80, 1'b1, 1'b1, 8'h01);
    check_outputs("b2b_b", 8'h80, 1'b0, 1'b0);
    idle(2);
    check_outputs("b2b_idle", 8'h80, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_top.md
# rx_top

UART receive front end: deserialises one frame per bit-clock from the serial line `rx_in` into a parallel word, checking even parity and the stop bit. It is the top of the receive path and is clocked directly at the bit rate: one `rx_clk` cycle per bit, no oversampling. It feeds the UART's parallel-side logic with `rx_data` and two error flags.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: data bits per frame. Taken from the shared UART parameter header.

Ports:
- `rx_clk`  in  1: bit-rate clock; all logic samples on its rising edge.
- `rx_rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `rx_in`  in  1: serial line. Idles high.
- `parity_bit_error`  out  1: last completed frame had a parity mismatch.
- `stop_bit_error`  out  1: last completed frame had its stop bit sampled low.
- `rx_data`  out  DATA_WIDTH: last completed frame's data, LSB = first data bit.

## Operation
- Frame format on `rx_in`, one bit per `rx_clk` edge:
  - start low, two samples
  - DATA_WIDTH data bits, LSB first
  - one even-parity bit
  - one stop bit, high
- Even parity rule: the parity bit equals the XOR of the data bits.
- FSM states, with transitions evaluated at each rising edge:
  - IDLE: `rx_in`=0 → START; otherwise stay.
  - START: confirms the start bit. `rx_in`=0 → DATA with the bit counter cleared. `rx_in`=1 is a false start → IDLE, no outputs change.
  - DATA: shift `rx_in` into the MSB of the shift register, shifting right, and increment the counter. After DATA_WIDTH samples → PARITY.
  - PARITY: capture `rx_in` as the received parity → STOP.
  - STOP: on this edge, update all three outputs → IDLE.
    - `rx_data` ← shift register.
    - `parity_bit_error` ← received parity XOR (XOR-reduce of the data).
    - `stop_bit_error` ← ~`rx_in`.
- The frame is always delivered, even when either error flag is set.
- Outputs hold their values until the next STOP edge; intermediate shifting never appears on `rx_data`.
- Back-to-back frames: from STOP the FSM returns to IDLE. A low on the next edge begins a new START, so the minimum gap between frames is zero extra cycles beyond the stop bit.
- A stop-bit error does not resynchronise specially; the FSM goes to IDLE regardless.

## Timing
- Reset, on a rising edge with `rx_rst_n`=0, overrides everything:
  - FSM → IDLE; counter and shift register → 0.
  - `rx_data`=0, `parity_bit_error`=0, `stop_bit_error`=0.
- Reset asserted mid-frame discards the partial frame. After release, the FSM waits in IDLE for a new falling start.
- Frame length: 2 + DATA_WIDTH + 2 edges, i.e. 12 for DATA_WIDTH=8.
- The first IDLE low sample is edge 0. Data is sampled at edges 2..9, parity at edge 10, stop at edge 11.
- Outputs are valid immediately after edge 11: zero-cycle latency after the stop sample, registered.
- All outputs are registered; no combinational path from `rx_in` to any output.

## Structure
- Shared UART header/package holds:
  - `DATA_WIDTH` (8)
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP
  - the bit-counter width, $clog2(DATA_WIDTH)+1
- Optional sub-module `rx_shift_reg`: a DATA_WIDTH right-shift register with shift enable and synchronous clear.
- FSM, counter and error logic stay in `rx_top`.

## Test plan
Clock period 20 in all scenarios.
- Nominal frame:
  - Stimulus: reset, then `rx_in` = 0,0 (start), data 1,0,1,0,1,0,1,0, parity 0, stop 1.
  - Response: after the stop edge, `rx_data`=8'h55 and both errors 0, holding while the line idles.
- Parity error:
  - Stimulus: same frame with parity 1.
  - Response: `rx_data`=8'h55, `parity_bit_error`=1, `stop_bit_error`=0.
- Stop error:
  - Stimulus: data 8'hA5 (LSB first 1,0,1,0,0,1,0,1), parity 0, stop 0.
  - Response: `rx_data`=8'hA5, `parity_bit_error`=0, `stop_bit_error`=1. A following good frame clears both flags.
- False start:
  - Stimulus: a single-cycle low pulse on `rx_in`, then high.
  - Response: FSM returns to IDLE, outputs unchanged. A subsequent valid frame of 8'h3C is received correctly.
- Reset mid-frame:
  - Stimulus: assert `rx_rst_n`=0 during data bit 4.
  - Response: all outputs 0 after that edge. The next full frame of 8'hFF with parity 0 gives `rx_data`=8'hFF and no errors.
- Back-to-back:
  - Stimulus: two frames, 8'h01 (parity 1) then 8'h80 (parity 1), with no idle gap.
  - Response: `rx_data`=8'h01 then 8'h80, each exactly 12 edges apart, with no errors.
